instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
- Registered decode stage directly downstream of the instruction fetch unit. Consumes the fetched 32-bit instruction and its 30-bit word PC; drives the IFU's steering flags (Jump, JumpReg, Branch, InvZero, TargetInstr, imm16) and datapath controls.
- Holds an IF/ID pipeline register with valid bit, stall hold, flush-to-bubble and load-use hazard detection.
- Requests a fetch hold when a load-use hazard is detected.

Parameters:
- PC_W, 30, word-address PC width
- RA_REG, 31, register index written by jal

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch presents a valid instruction this cycle
- instr_in  in  32  fetched instruction
- pc_in  in  PC_W  word PC of instr_in
- stall_in  in  1  downstream cannot accept; hold register
- flush  in  1  squash held and incoming instruction (taken branch/jump resolved)
- out_valid  out  1  decoded outputs describe a real instruction
- pc_out  out  PC_W  PC of held instruction
- Jump  out  1  j or jal
- JumpReg  out  1  jr
- Branch  out  1  beq or bne
- InvZero  out  1  1 for bne
- TargetInstr  out  26  instr[25:0]
- imm16  out  16  instr[15:0]
- rs, rt  out  5 each  source register fields
- wr_reg  out  5  destination: rd (R-type), rt (I-type), RA_REG (jal)
- RegWrite, MemWrite, MemToReg, ALUSrc  out  1 each  datapath controls
- ALUCtrl  out  3  000 add, 001 sub, 010 xor, 011 slt
- illegal  out  1  valid instruction with unsupported opcode/funct
- hazard_stall  out  1  hold IFU PC and re-present the same instruction

Behaviour:
- Reset: register cleared to nop (all zero), out_valid=0, all control outputs 0, hazard_stall=0, pc_out=0. Takes effect at the posedge where reset=1 and overrides all other inputs, including mid-stall.
- Latency: one cycle. instr_in/pc_in captured at posedge; decoded outputs are combinational from the held register.
- Control outputs are gated by out_valid; when out_valid=0, every control output is 0.
- Supported set:
  - R-type (op 00): add 20, sub 22, slt 2A, jr 08
  - lw 23, sw 2B, addi 08, xori 0E, beq 04, bne 05, j 02, jal 03
  - Anything else: illegal=1 and all write/jump/branch controls 0.
- jal: Jump=1, RegWrite=1, wr_reg=RA_REG.
- imm16 is passed raw; sign extension stays in consumers.
- Update priority each posedge:
  1. reset
  2. flush → out_valid=0, hazard state cleared
  3. stall_in → hold everything
  4. hazard → insert bubble (out_valid=0), keep nothing from fetch
  5. otherwise capture, with out_valid = in_valid
- Load-use hazard is combinational:
  - hazard_stall=1 when the held instruction is a valid lw with rt≠0, in_valid=1, and incoming rs==held rt, or incoming rt==held rt for R-type/sw/beq/bne.
  - Lasts exactly one cycle because the bubble removes the lw from the held slot.
  - Never asserted while flush=1.
- stall_in and hazard together: stall_in wins; hazard_stall stays asserted, computed from the unchanged held lw.
- flush and stall_in together: flush wins.

Decomposition:
- Shared package: opcode/funct constants, ALUCtrl encodings, RA_REG, and a decoded-control struct.
- One sub-module, instr_decoder: purely combinational, 32-bit instruction to control struct, plus illegal.
- Top level holds the register, valid, priority logic and hazard compare.

Test Plan:
- Reset then in_valid=1 with add $3,$1,$2 (0x00221820) at pc 5 → next cycle out_valid=1, RegWrite=1, wr_reg=3, ALUCtrl=000, pc_out=5.
- bne $1,$2,+3 (0x14220003) → Branch=1, InvZero=1, imm16=0003, RegWrite=0. Same test with beq → InvZero=0.
- jal 0x000009 (0x0C000009) → Jump=1, TargetInstr=9, RegWrite=1, wr_reg=31. jr $31 (0x03E00008) → JumpReg=1, Jump=0.
- lw $4,0($1) followed by add $5,$4,$2 → hazard_stall=1 for exactly one cycle, then a bubble with out_valid=0, then add decoded. With add $5,$6,$2 instead → no stall.
- stall_in=1 for 3 cycles with sw held → outputs constant. flush=1 during the stall → out_valid=0 next cycle.
- Opcode 0x3F → illegal=1 with all controls 0. Reset asserted mid-stall → all outputs 0 next cycle.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// rtl/instr_decode_pkg.sv - opcode/funct constants, ALU encodings and decoded-control struct
package instr_decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam int DEF_RA_REG = 31;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_XOR = 3'b010,
        ALU_SLT = 3'b011
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_RD   = 2'd1,
        DST_RT   = 2'd2,
        DST_RA   = 2'd3
    } dst_sel_e;

    typedef struct packed {
        logic      jump;
        logic      jump_reg;
        logic      branch;
        logic      inv_zero;
        logic      reg_write;
        logic      mem_write;
        logic      mem_to_reg;
        logic      alu_src;
        alu_ctrl_e alu_ctrl;
        dst_sel_e  dst_sel;
        logic      illegal;
    } ctrl_t;

    // Opcodes whose rt field is a source operand (matters for load-use compare).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/instr_decode_stage_decoder.sv
// rtl/instr_decode_stage_decoder.sv - combinational instruction word to control struct
module instr_decoder
    import instr_decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr_i[31:26];
    assign funct = instr_i[5:0];

    always_comb begin
        ctrl_o = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        ctrl_o.reg_write = 1'b1;
                        ctrl_o.dst_sel   = DST_RD;
                        ctrl_o.alu_ctrl  = ALU_ADD;
                    end
                    FN_SUB: begin
                        ctrl_o.reg_write = 1'b1;
                        ctrl_o.dst_sel   = DST_RD;
                        ctrl_o.alu_ctrl  = ALU_SUB;
                    end
                    FN_SLT: begin
                        ctrl_o.reg_write = 1'b1;
                        ctrl_o.dst_sel   = DST_RD;
                        ctrl_o.alu_ctrl  = ALU_SLT;
                    end
                    FN_JR:   ctrl_o.jump_reg = 1'b1;
                    default: ctrl_o.illegal  = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.dst_sel    = DST_RT;
            end
            OP_SW: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.dst_sel   = DST_RT;
            end
            OP_XORI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.dst_sel   = DST_RT;
                ctrl_o.alu_ctrl  = ALU_XOR;
            end
            OP_BEQ: begin
                ctrl_o.branch   = 1'b1;
                ctrl_o.alu_ctrl = ALU_SUB;
            end
            OP_BNE: begin
                ctrl_o.branch   = 1'b1;
                ctrl_o.inv_zero = 1'b1;
                ctrl_o.alu_ctrl = ALU_SUB;
            end
            OP_J:   ctrl_o.jump = 1'b1;
            OP_JAL: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.dst_sel   = DST_RA;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - IF/ID register with stall/flush priority and load-use hazard detect
module instr_decode_stage
    import instr_decode_pkg::*;
#(
    parameter int PC_W   = 30,
    parameter int RA_REG = DEF_RA_REG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     instr_in,
    input  logic [PC_W-1:0] pc_in,
    input  logic            stall_in,
    input  logic            flush,
    output logic            out_valid,
    output logic [PC_W-1:0] pc_out,
    output logic            Jump,
    output logic            JumpReg,
    output logic            Branch,
    output logic            InvZero,
    output logic [25:0]     TargetInstr,
    output logic [15:0]     imm16,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      wr_reg,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic            MemToReg,
    output logic            ALUSrc,
    output logic [2:0]      ALUCtrl,
    output logic            illegal,
    output logic            hazard_stall
);

    localparam logic [4:0] RA_IDX = RA_REG[4:0];

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q,    pc_d;
    ctrl_t           ctrl;
    logic            held_lw;
    logic [4:0]      held_rt;

    instr_decoder u_decoder (
        .instr_i (instr_q),
        .ctrl_o  (ctrl)
    );

    // A held lw with a nonzero rt blocks any consumer arriving right behind it.
    assign held_rt = instr_q[20:16];
    assign held_lw = valid_q && (instr_q[31:26] == OP_LW) && (held_rt != 5'd0);
    assign hazard_stall = !flush && held_lw && in_valid &&
                          ((instr_in[25:21] == held_rt) ||
                           (reads_rt(instr_in[31:26]) && (instr_in[20:16] == held_rt)));

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush || (!stall_in && hazard_stall)) begin
            valid_d = 1'b0;
            instr_d = '0;
            pc_d    = '0;
        end else if (!stall_in) begin
            valid_d = in_valid;
            instr_d = instr_in;
            pc_d    = pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid   = valid_q;
    assign pc_out      = pc_q;
    assign TargetInstr = instr_q[25:0];
    assign imm16       = instr_q[15:0];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];

    assign Jump     = valid_q & ctrl.jump;
    assign JumpReg  = valid_q & ctrl.jump_reg;
    assign Branch   = valid_q & ctrl.branch;
    assign InvZero  = valid_q & ctrl.inv_zero;
    assign RegWrite = valid_q & ctrl.reg_write;
    assign MemWrite = valid_q & ctrl.mem_write;
    assign MemToReg = valid_q & ctrl.mem_to_reg;
    assign ALUSrc   = valid_q & ctrl.alu_src;
    assign ALUCtrl  = valid_q ? ctrl.alu_ctrl : ALU_ADD;
    assign illegal  = valid_q & ctrl.illegal;

    always_comb begin
        wr_reg = 5'd0;
        if (valid_q) begin
            case (ctrl.dst_sel)
                DST_RD:  wr_reg = instr_q[15:11];
                DST_RT:  wr_reg = instr_q[20:16];
                DST_RA:  wr_reg = RA_IDX;
                default: wr_reg = 5'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - self-checking bench for instr_decode_stage
module tb_instr_decode_stage;
    localparam int PC_W = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, in_valid, stall_in, flush;
    logic [31:0]     instr_in;
    logic [PC_W-1:0] pc_in;
    logic            out_valid, Jump, JumpReg, Branch, InvZero;
    logic [PC_W-1:0] pc_out;
    logic [25:0]     TargetInstr;
    logic [15:0]     imm16;
    logic [4:0]      rs, rt, wr_reg;
    logic            RegWrite, MemWrite, MemToReg, ALUSrc, illegal, hazard_stall;
    logic [2:0]      ALUCtrl;

    instr_decode_stage #(.PC_W(PC_W), .RA_REG(31)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instr_in(instr_in), .pc_in(pc_in),
        .stall_in(stall_in), .flush(flush), .out_valid(out_valid), .pc_out(pc_out),
        .Jump(Jump), .JumpReg(JumpReg), .Branch(Branch), .InvZero(InvZero),
        .TargetInstr(TargetInstr), .imm16(imm16), .rs(rs), .rt(rt), .wr_reg(wr_reg),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
        .ALUCtrl(ALUCtrl), .illegal(illegal), .hazard_stall(hazard_stall)
    );

    // {Jump,JumpReg,Branch,InvZero,RegWrite,MemWrite,MemToReg,ALUSrc,ALUCtrl[2:0],illegal}
    wire [11:0] ctl_v = {Jump, JumpReg, Branch, InvZero, RegWrite, MemWrite,
                         MemToReg, ALUSrc, ALUCtrl, illegal};

    int tests = 0;
    int fails = 0;

    logic            m_valid;
    logic [31:0]     m_instr;
    logic [PC_W-1:0] m_pc;

    // Expected {ctl_v, wr_reg} for a valid instruction, straight from the instruction table.
    function automatic logic [16:0] exp_dec(input logic [31:0] ins);
        logic [4:0] r_t, r_d;
        r_t = ins[20:16];
        r_d = ins[15:11];
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20:   return {12'h080, r_d};
                6'h22:   return {12'h082, r_d};
                6'h2A:   return {12'h086, r_d};
                6'h08:   return {12'h400, 5'd0};
                default: return {12'h001, 5'd0};
            endcase
            6'h23:   return {12'h0B0, r_t};
            6'h2B:   return {12'h050, 5'd0};
            6'h08:   return {12'h090, r_t};
            6'h0E:   return {12'h094, r_t};
            6'h04:   return {12'h202, 5'd0};
            6'h05:   return {12'h302, 5'd0};
            6'h02:   return {12'h800, 5'd0};
            6'h03:   return {12'h880, 5'd31};
            default: return {12'h001, 5'd0};
        endcase
    endfunction

    function automatic bit model_hazard();
        logic [4:0] hrt;
        logic [5:0] op;
        if (flush || !in_valid || !m_valid || m_instr[31:26] != 6'h23) return 1'b0;
        hrt = m_instr[20:16];
        op  = instr_in[31:26];
        if (hrt == 5'd0) return 1'b0;
        if (instr_in[25:21] == hrt) return 1'b1;
        if ((op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05) && instr_in[20:16] == hrt)
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] op, fn;
        case ($urandom_range(0, 12))
            0, 1: op = 6'h00;
            2, 3: op = 6'h23;
            4:    op = 6'h2B;
            5:    op = 6'h08;
            6:    op = 6'h0E;
            7:    op = 6'h04;
            8:    op = 6'h05;
            9:    op = 6'h02;
            10:   op = 6'h03;
            default: op = 6'(32 + $urandom_range(16, 31));
        endcase
        case ($urandom_range(0, 4))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h2A;
            3: fn = 6'h08;
            default: fn = 6'($urandom);
        endcase
        return {op, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                5'($urandom_range(0, 31)), 5'($urandom), fn};
    endfunction

    task automatic set_in(input logic r, input logic v, input logic [31:0] ins,
                          input logic [PC_W-1:0] pc, input logic st, input logic fl);
        reset = r; in_valid = v; instr_in = ins; pc_in = pc; stall_in = st; flush = fl;
        #2;
    endtask

    task automatic tick();
        bit hz;
        hz = model_hazard();
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0; m_instr = '0; m_pc = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (stall_in) begin
            m_valid = m_valid;
        end else if (hz) begin
            m_valid = 1'b0;
        end else begin
            m_valid = in_valid; m_instr = instr_in; m_pc = pc_in;
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(1, 1, 32'h00221820, 30'd7, 0, 0);
        tick();
        set_in(0, 0, 32'h0, '0, 0, 0);
        tests++;
        if (out_valid !== 1'b0 || ctl_v !== 12'h000 || hazard_stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: valid=%b ctl=%h hz=%b, want 0/000/0", out_valid, ctl_v, hazard_stall);
        end
        tests++;
        if (pc_out !== '0 || wr_reg !== 5'd0 || imm16 !== 16'd0 || TargetInstr !== 26'd0) begin
            fails++;
            $display("FAIL reset_fields: pc=%h wr=%0d imm=%h tgt=%h, want all 0", pc_out, wr_reg, imm16, TargetInstr);
        end
    endtask

    task automatic test_alu_branch();
        set_in(0, 1, 32'h00221820, 30'd5, 0, 0);
        tick();
        set_in(0, 1, 32'h14220003, 30'd6, 0, 0);
        tests++;
        if (out_valid !== 1'b1 || ctl_v !== 12'h080 || wr_reg !== 5'd3 || pc_out !== 30'd5) begin
            fails++;
            $display("FAIL add: valid=%b ctl=%h wr=%0d pc=%0d, want 1/080/3/5", out_valid, ctl_v, wr_reg, pc_out);
        end
        tick();
        set_in(0, 1, 32'h10220003, 30'd7, 0, 0);
        tests++;
        if (ctl_v !== 12'h302 || imm16 !== 16'h0003 || RegWrite !== 1'b0) begin
            fails++;
            $display("FAIL bne: ctl=%h imm=%h rw=%b, want 302/0003/0", ctl_v, imm16, RegWrite);
        end
        tick();
        set_in(0, 0, 32'h0, '0, 0, 0);
        tests++;
        if (ctl_v !== 12'h202 || InvZero !== 1'b0) begin
            fails++;
            $display("FAIL beq: ctl=%h invzero=%b, want 202/0", ctl_v, InvZero);
        end
    endtask

    task automatic test_jumps();
        set_in(0, 1, 32'h0C000009, 30'd20, 0, 0);
        tick();
        set_in(0, 1, 32'h03E00008, 30'd21, 0, 0);
        tests++;
        if (ctl_v !== 12'h880 || TargetInstr !== 26'd9 || wr_reg !== 5'd31) begin
            fails++;
            $display("FAIL jal: ctl=%h tgt=%0d wr=%0d, want 880/9/31", ctl_v, TargetInstr, wr_reg);
        end
        tick();
        set_in(0, 0, 32'h0, '0, 0, 0);
        tests++;
        if (JumpReg !== 1'b1 || Jump !== 1'b0 || ctl_v !== 12'h400) begin
            fails++;
            $display("FAIL jr: jr=%b j=%b ctl=%h, want 1/0/400", JumpReg, Jump, ctl_v);
        end
    endtask

    task automatic test_load_use();
        set_in(0, 1, 32'h8C240000, 30'd30, 0, 0);
        tick();
        set_in(0, 1, 32'h00822820, 30'd31, 0, 0);
        tests++;
        if (hazard_stall !== 1'b1 || ctl_v !== 12'h0B0) begin
            fails++;
            $display("FAIL lu_stall: hz=%b ctl=%h, want 1/0B0", hazard_stall, ctl_v);
        end
        tick();
        tests++;
        if (hazard_stall !== 1'b0 || out_valid !== 1'b0 || ctl_v !== 12'h000) begin
            fails++;
            $display("FAIL lu_bubble: hz=%b valid=%b ctl=%h, want 0/0/000", hazard_stall, out_valid, ctl_v);
        end
        tick();
        set_in(0, 1, 32'h8C240000, 30'd40, 0, 0);
        tests++;
        if (out_valid !== 1'b1 || wr_reg !== 5'd5 || pc_out !== 30'd31) begin
            fails++;
            $display("FAIL lu_after: valid=%b wr=%0d pc=%0d, want 1/5/31", out_valid, wr_reg, pc_out);
        end
        tick();
        set_in(0, 1, 32'h00C22820, 30'd41, 0, 0);
        tests++;
        if (hazard_stall !== 1'b0) begin
            fails++;
            $display("FAIL lu_nodep: hz=%b, want 0", hazard_stall);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || pc_out !== 30'd41 || wr_reg !== 5'd5) begin
            fails++;
            $display("FAIL lu_nodep_next: valid=%b pc=%0d wr=%0d, want 1/41/5", out_valid, pc_out, wr_reg);
        end
        // Stall while hazard pending: hazard stays up, lw stays held.
        set_in(0, 1, 32'h8C240000, 30'd42, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, 32'h00822820, 30'd43, 1, 0);
            tests++;
            if (hazard_stall !== 1'b1 || pc_out !== 30'd42) begin
                fails++;
                $display("FAIL lu_stalled[%0d]: hz=%b pc=%0d, want 1/42", i, hazard_stall, pc_out);
            end
            tick();
        end
        set_in(0, 1, 32'h00822820, 30'd43, 0, 1);
        tests++;
        if (hazard_stall !== 1'b0) begin
            fails++;
            $display("FAIL lu_flush: hz=%b, want 0", hazard_stall);
        end
        tick();
    endtask

    task automatic test_stall_flush();
        set_in(0, 1, 32'hAC220004, 30'd50, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, rand_instr(), 30'(60 + i), 1, 0);
            tick();
            tests++;
            if (out_valid !== 1'b1 || ctl_v !== 12'h050 || imm16 !== 16'h0004 || pc_out !== 30'd50) begin
                fails++;
                $display("FAIL stall[%0d]: valid=%b ctl=%h imm=%h pc=%0d, want 1/050/0004/50",
                         i, out_valid, ctl_v, imm16, pc_out);
            end
        end
        set_in(0, 1, 32'h00221820, 30'd70, 1, 1);
        tick();
        set_in(0, 0, 32'h0, '0, 0, 0);
        tests++;
        if (out_valid !== 1'b0 || ctl_v !== 12'h000) begin
            fails++;
            $display("FAIL stall_flush: valid=%b ctl=%h, want 0/000", out_valid, ctl_v);
        end
    endtask

    task automatic test_illegal_reset();
        set_in(0, 1, 32'hFC000000, 30'd80, 0, 0);
        tick();
        set_in(0, 1, 32'hAC220004, 30'd81, 0, 0);
        tests++;
        if (illegal !== 1'b1 || ctl_v !== 12'h001 || wr_reg !== 5'd0) begin
            fails++;
            $display("FAIL illegal: ill=%b ctl=%h wr=%0d, want 1/001/0", illegal, ctl_v, wr_reg);
        end
        tick();
        set_in(0, 1, 32'h00221820, 30'd82, 1, 0);
        tick();
        set_in(1, 1, 32'h00221820, 30'd83, 1, 0);
        tick();
        set_in(0, 1, 32'h00221820, 30'd84, 1, 0);
        tests++;
        if (out_valid !== 1'b0 || ctl_v !== 12'h000 || pc_out !== '0 || wr_reg !== 5'd0) begin
            fails++;
            $display("FAIL reset_in_stall: valid=%b ctl=%h pc=%0d wr=%0d, want all 0",
                     out_valid, ctl_v, pc_out, wr_reg);
        end
        tick();
    endtask

    task automatic test_random();
        logic [16:0] e;
        logic [11:0] ectl;
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8, rand_instr(),
                   30'($urandom), $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
            e    = m_valid ? exp_dec(m_instr) : 17'd0;
            ectl = e[16:5];
            tests++;
            if (out_valid !== m_valid || ctl_v !== ectl || hazard_stall !== model_hazard()) begin
                fails++;
                $display("FAIL rnd_ctl[%0d]: valid=%b ctl=%h hz=%b, want %b/%h/%b",
                         n, out_valid, ctl_v, hazard_stall, m_valid, ectl, model_hazard());
            end
            if (m_valid) begin
                tests++;
                if (pc_out !== m_pc || wr_reg !== e[4:0] || TargetInstr !== m_instr[25:0] ||
                    rs !== m_instr[25:21] || rt !== m_instr[20:16] || imm16 !== m_instr[15:0]) begin
                    fails++;
                    $display("FAIL rnd_fields[%0d]: pc=%h wr=%0d tgt=%h, want %h/%0d/%h",
                             n, pc_out, wr_reg, TargetInstr, m_pc, e[4:0], m_instr[25:0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        m_valid = 1'b0; m_instr = '0; m_pc = '0;
        set_in(1, 0, 32'h0, '0, 0, 0);
        test_reset();
        test_alu_branch();
        test_jumps();
        test_load_use();
        test_stall_flush();
        test_illegal_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
